// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 8N1 oversampling UART receiver with 3-sample majority voting
//
// Recovers 8N1 frames from an asynchronous, idle-high serial line. Each bit
// period is CLK_DIV clocks, and each bit is decided by a majority vote of three
// synchronized samples around the middle of the bit. Received bytes are
// offered on a valid/ready handshake. Framing errors and overruns are reported
// as single-cycle pulses.
//
// Parameters:
//   CLK_DIV      clocks per bit period (even, >= 8)
// Ports:
//   i_clk_rx     block clock
//   i_reset      asynchronous active-high reset
//   i_rxd        serial input, asynchronous to i_clk_rx, idle high
//   i_ready      consumer accepts o_data when o_valid & i_ready
//   o_data       last received byte, LSB received first
//   o_valid      o_data holds a byte that has not been accepted
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: byte completed while previous one unaccepted
//   o_busy       receiver FSM is not idle
module uart_rx_os #(
  parameter int CLK_DIV = 16
) (
  input  logic       i_clk_rx,
  input  logic       i_reset,
  input  logic       i_rxd,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int MID = CLK_DIV / 2;
  localparam int CW  = $clog2(CLK_DIV);

  localparam logic [CW-1:0] CNT_LO   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          rxd_meta;
  logic          rxd_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          smp_lo;
  logic          smp_mid;
  logic          decide;
  logic          last;
  logic          maj;
  logic          stop_decide;
  logic          load_byte;
  logic          overrun_set;
  logic          frame_err_set;

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // never fakes a start bit.
  always_ff @(posedge i_clk_rx or posedge i_reset) begin
    if (i_reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= i_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // The third vote is the live synchronized sample in the decision cycle.
  assign decide = (cnt == CNT_DEC);
  assign last   = (cnt == CNT_LAST);
  assign maj    = (smp_lo & smp_mid) | (smp_lo & rxd_s) | (smp_mid & rxd_s);

  // State register
  always_ff @(posedge i_clk_rx or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!rxd_s) state_nxt = S_START;
      end
      S_START: begin
        if (decide && maj) state_nxt = S_IDLE;
        else if (last)     state_nxt = S_DATA;
      end
      S_DATA: begin
        if (last && bit_idx == 3'd7) state_nxt = S_STOP;
      end
      S_STOP: begin
        // Leave at the decision point rather than the end of the stop bit so
        // a following start bit is never missed.
        if (decide) state_nxt = maj ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rxd_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    o_busy        = (state != S_IDLE);
    stop_decide   = (state == S_STOP) && decide;
    load_byte     = stop_decide && maj && (!o_valid || i_ready);
    overrun_set   = stop_decide && maj && o_valid && !i_ready;
    frame_err_set = stop_decide && !maj;
  end

  // Bit timing, vote samples and shift register
  always_ff @(posedge i_clk_rx or posedge i_reset) begin
    if (i_reset) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      smp_lo  <= 1'b1;
      smp_mid <= 1'b1;
    end else begin
      if (state == S_IDLE || state_nxt == S_IDLE || state_nxt == S_BREAK || last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (cnt == CNT_LO)  smp_lo  <= rxd_s;
      if (cnt == CNT_MID) smp_mid <= rxd_s;

      if (state == S_START) begin
        bit_idx <= 3'd0;
      end else if (state == S_DATA && last) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (state == S_DATA && decide) begin
        shift <= {maj, shift[7:1]};
      end
    end
  end

  // Byte handshake and status pulses
  always_ff @(posedge i_clk_rx or posedge i_reset) begin
    if (i_reset) begin
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= frame_err_set;
      o_overrun   <= overrun_set;
      if (load_byte) begin
        o_data  <= shift;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
